// File: rtl/countdown_timer.sv
// countdown_timer: BCD M:SS.d countdown with tenth-second prescaler and alarm
module countdown_timer #(
  parameter int TICK_DIV = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       start_resume,
  input  logic       stop,
  input  logic [3:0] pre_min0,
  input  logic [3:0] pre_sec1,
  input  logic [3:0] pre_sec0,
  input  logic [3:0] pre_dsec0,
  output logic [3:0] min0,
  output logic [3:0] sec1,
  output logic [3:0] sec0,
  output logic [3:0] dsec0,
  output logic       running,
  output logic       done
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
  state_t state, state_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [3:0] min0_nx, sec1_nx, sec0_nx, dsec0_nx;
  logic [3:0] dec_min0, dec_sec1, dec_sec0, dec_dsec0;
  logic b0, b1, b2, tick, zero, dec_zero;
  always_comb begin
    b0 = dsec0 == 4'd0;
    b1 = b0 && sec0 == 4'd0;
    b2 = b1 && sec1 == 4'd0;
    dec_dsec0 = b0 ? 4'd9 : dsec0 - 4'd1;
    dec_sec0 = b0 ? (sec0 == 4'd0 ? 4'd9 : sec0 - 4'd1) : sec0;
    dec_sec1 = b1 ? (sec1 == 4'd0 ? 4'd5 : sec1 - 4'd1) : sec1;
    dec_min0 = b2 ? min0 - 4'd1 : min0;
    zero = {min0, sec1, sec0, dsec0} == 16'h0000;
    dec_zero = {dec_min0, dec_sec1, dec_sec0, dec_dsec0} == 16'h0000;
    tick = state == RUN && presc == PW'(TICK_DIV - 1);
  end
  always_comb begin
    state_nx = state;
    presc_nx = presc;
    {min0_nx, sec1_nx, sec0_nx, dsec0_nx} = {min0, sec1, sec0, dsec0};
    if (load && state != RUN) begin
      min0_nx = pre_min0 > 4'd9 ? 4'd9 : pre_min0;
      sec1_nx = pre_sec1 > 4'd5 ? 4'd5 : pre_sec1;
      sec0_nx = pre_sec0 > 4'd9 ? 4'd9 : pre_sec0;
      dsec0_nx = pre_dsec0 > 4'd9 ? 4'd9 : pre_dsec0;
      presc_nx = '0;
      state_nx = IDLE;
    end else if (stop && state == RUN) begin
      state_nx = PAUSED;
    end else if (start_resume && (state == IDLE || state == PAUSED)) begin
      state_nx = zero ? DONE : RUN;
    end else if (state == RUN) begin
      presc_nx = tick ? '0 : presc + PW'(1);
      if (tick) begin
        {min0_nx, sec1_nx, sec0_nx, dsec0_nx} = {dec_min0, dec_sec1, dec_sec0, dec_dsec0};
        state_nx = dec_zero ? DONE : RUN;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      presc <= '0;
      {min0, sec1, sec0, dsec0} <= 16'h0000;
      running <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      presc <= presc_nx;
      {min0, sec1, sec0, dsec0} <= {min0_nx, sec1_nx, sec0_nx, dsec0_nx};
      running <= state_nx == RUN;
      done <= state_nx == DONE;
    end
  end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed stimulus, tenths-integer model checked every cycle
module tb_countdown_timer;
  localparam int TD = 4;
  logic clk = 1'b0;
  logic reset, load, start_resume, stop;
  logic [3:0] pre_min0, pre_sec1, pre_sec0, pre_dsec0;
  logic [3:0] min0, sec1, sec0, dsec0;
  logic running, done;
  int errors = 0;
  int checks = 0;
  int t_rem = 0;
  int pc = 0;
  int mode = 0;
  bit armed = 1'b0;

  countdown_timer #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .load(load), .start_resume(start_resume), .stop(stop),
    .pre_min0(pre_min0), .pre_sec1(pre_sec1), .pre_sec0(pre_sec0), .pre_dsec0(pre_dsec0),
    .min0(min0), .sec1(sec1), .sec0(sec0), .dsec0(dsec0), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int clampv(input int v, input int mx);
    return v > mx ? mx : v;
  endfunction

  // mode: 0 idle, 1 run, 2 paused, 3 done; time held as whole tenths remaining
  always @(posedge clk) begin
    if (!reset) begin
      mode = 0; t_rem = 0; pc = 0; armed = 1'b1;
    end else if (load && mode != 1) begin
      t_rem = clampv(int'(pre_min0), 9) * 600 + clampv(int'(pre_sec1), 5) * 100
            + clampv(int'(pre_sec0), 9) * 10 + clampv(int'(pre_dsec0), 9);
      pc = 0; mode = 0;
    end else if (stop && mode == 1) begin
      mode = 2;
    end else if (start_resume && (mode == 0 || mode == 2)) begin
      mode = t_rem == 0 ? 3 : 1;
    end else if (mode == 1) begin
      pc = pc + 1;
      if (pc == TD) begin
        pc = 0;
        t_rem = t_rem - 1;
        if (t_rem == 0) mode = 3;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      logic [17:0] exp_v, act_v;
      exp_v = {4'(t_rem / 600), 4'((t_rem % 600) / 100), 4'((t_rem % 100) / 10), 4'(t_rem % 10),
               mode == 1, mode == 3};
      act_v = {min0, sec1, sec0, dsec0, running, done};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model t=%0t got=%h want=%h", $time, act_v, exp_v);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic preset(input logic [3:0] m, input logic [3:0] s1, input logic [3:0] s0, input logic [3:0] d);
    {pre_min0, pre_sec1, pre_sec0, pre_dsec0} = {m, s1, s0, d};
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  function automatic logic [17:0] outs();
    return {min0, sec1, sec0, dsec0, running, done};
  endfunction

  initial begin
    reset = 1'b0; load = 1'b0; start_resume = 1'b0; stop = 1'b0;
    {pre_min0, pre_sec1, pre_sec0, pre_dsec0} = 16'h0000;
    step(2);
    lit("reset", outs(), {16'h0000, 2'b00});
    reset = 1'b1;
    preset(4'd1, 4'd2, 4'd3, 4'd4);
    lit("load_1234", outs(), {16'h1234, 2'b00});
    preset(4'd1, 4'd0, 4'd0, 4'd0);
    start_resume = 1'b1; step(1); start_resume = 1'b0;
    lit("run_start", outs(), {16'h1000, 2'b10});
    step(4);
    lit("borrow_0599", outs(), {16'h0599, 2'b10});
    step(4);
    lit("dec_0598", outs(), {16'h0598, 2'b10});
    {pre_min0, pre_sec1, pre_sec0, pre_dsec0} = 16'h2222;
    load = 1'b1; step(1); load = 1'b0;
    lit("load_in_run", outs(), {16'h0598, 2'b10});
    stop = 1'b1; start_resume = 1'b1; step(1); stop = 1'b0; start_resume = 1'b0;
    lit("stop_wins", outs(), {16'h0598, 2'b00});
    preset(4'd0, 4'd0, 4'd0, 4'd5);
    start_resume = 1'b1; step(1); start_resume = 1'b0;
    step(6);
    stop = 1'b1; step(1); stop = 1'b0;
    lit("paused", outs(), {16'h0004, 2'b00});
    step(20);
    lit("pause_hold", outs(), {16'h0004, 2'b00});
    start_resume = 1'b1; step(1); start_resume = 1'b0;
    step(1);
    lit("resume_partial", outs(), {16'h0004, 2'b10});
    step(1);
    lit("resume_dec", outs(), {16'h0003, 2'b10});
    reset = 1'b0; load = 1'b1; start_resume = 1'b1; step(1);
    reset = 1'b1; load = 1'b0; start_resume = 1'b0;
    lit("mid_reset", outs(), {16'h0000, 2'b00});
    preset(4'd0, 4'd0, 4'd0, 4'd2);
    start_resume = 1'b1; step(1); start_resume = 1'b0;
    step(7);
    lit("pre_expiry", outs(), {16'h0001, 2'b10});
    step(1);
    lit("expiry", outs(), {16'h0000, 2'b01});
    start_resume = 1'b1; stop = 1'b1; step(50); start_resume = 1'b0; stop = 1'b0;
    lit("done_hold", outs(), {16'h0000, 2'b01});
    preset(4'd0, 4'd0, 4'd0, 4'd0);
    lit("load_clears_done", outs(), {16'h0000, 2'b00});
    start_resume = 1'b1; step(1); start_resume = 1'b0;
    lit("zero_start", outs(), {16'h0000, 2'b01});
    preset(4'd0, 4'd7, 4'd0, 4'd12);
    lit("clamp_sec1_dsec0", outs(), {16'h0509, 2'b00});
    preset(4'd15, 4'd0, 4'd15, 4'd0);
    lit("clamp_min0_sec0", outs(), {16'h9090, 2'b00});
    preset(4'd0, 4'd1, 4'd0, 4'd0);
    start_resume = 1'b1; step(1); start_resume = 1'b0;
    step(4);
    lit("borrow_sec1", outs(), {16'h0099, 2'b10});
    step(12);
    lit("run_on", outs(), {16'h0096, 2'b10});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Down-counting companion to the team's stopwatch: loads a preset M:SS.d value and counts it down to 0:00.0 in tenth-second steps, then raises an alarm.
- Same BCD digit format as the stopwatch outputs, so both blocks share the display path.
- Carries its own tenth-second prescaler; one clock domain.

Parameters:
- TICK_DIV, 10, clk cycles per tenth-second decrement; legal range is 2 or more. Benches use 4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- load  input  1  level; copies preset digits into the counter when permitted.
- start_resume  input  1  level; starts or resumes the countdown.
- stop  input  1  level; pauses the countdown.
- pre_min0  input  4  preset minutes digit, BCD 0-9.
- pre_sec1  input  4  preset tens-of-seconds digit, BCD 0-5.
- pre_sec0  input  4  preset seconds digit, BCD 0-9.
- pre_dsec0  input  4  preset tenths digit, BCD 0-9.
- min0, sec1, sec0, dsec0  output  4 each  current remaining time, BCD.
- running  output  1  1 while in RUN.
- done  output  1  alarm level; 1 while in DONE.

Behaviour:
- Reset (reset=0 at an edge):
  - state goes to IDLE.
  - All digits, prescaler, running and done are cleared to 0.
  - Reset overrides all other inputs and takes effect mid-countdown.
- States: IDLE, RUN, PAUSED, DONE. Registered outputs: running=(state==RUN), done=(state==DONE).
- Per-edge priority: reset > load > stop > start_resume.
- load:
  - Accepted in IDLE, PAUSED or DONE.
  - Copies the preset digits, clears the prescaler and goes to IDLE.
  - Ignored in RUN.
  - Out-of-range preset digits are clamped at load: min0, sec0 and dsec0 above 9 become 9; sec1 above 5 becomes 5.
- start_resume:
  - From IDLE or PAUSED with a nonzero count: go to RUN.
  - From IDLE or PAUSED with the count at 0:00.0: go directly to DONE; no decrement occurs.
  - Ignored in RUN and DONE.
- stop:
  - In RUN: go to PAUSED.
  - Digits and prescaler are held, so resume continues the partial tenth; no tick is lost or added.
  - Ignored in other states.
  - stop and start_resume both high at the same edge: stop wins.
- Prescaler:
  - Counts 0..TICK_DIV-1, and only in RUN.
  - At terminal count it wraps to 0 and issues one decrement that same edge.
  - First decrement lands TICK_DIV cycles after RUN is entered from a cleared prescaler.
- Decrement (BCD borrow chain):
  - dsec0: if 0, becomes 9 and borrows; otherwise decrements by 1.
  - sec0: on borrow-in, if 0, becomes 9 and borrows; otherwise decrements.
  - sec1: on borrow-in, if 0, becomes 5 and borrows; otherwise decrements.
  - min0: on borrow-in, decrements.
  - Example: 1:00.0 decrements to 0:59.9.
- Reaching zero:
  - The decrement edge that produces 0:00.0 also moves state to DONE; running falls and done rises on that edge.
  - No wrap below zero.
- DONE:
  - Digits hold at 0.
  - done stays 1 until load or reset.
  - start_resume and stop are ignored.
- Digits never leave BCD range. Outputs change only on clk edges.

Test Plan:
- Reset and load: reset=0 for 2 cycles, then reset=1 with load=1 and preset 1:23.4 → digits 1,2,3,4 next edge; running=0, done=0; state IDLE.
- Countdown and borrow: preset 1:00.0, TICK_DIV=4, start_resume pulse → running=1; after 4 cycles digits read 0,5,9,9; after 8 cycles 0,5,9,8.
- Pause and resume: preset 0:00.5, start, stop after 6 cycles (one decrement done, prescaler=2) → digits freeze at 0:00.4 for 20 cycles. Resume → next decrement arrives 2 cycles later.
- Expiry: preset 0:00.2, start → after 8 cycles digits 0:00.0, running=0, done=1 on the same edge; done holds for 50 cycles; start_resume ignored.
- Zero start and clamping: load 0:00.0 then start → DONE next edge with no decrement. Load pre_sec1=7, pre_dsec0=12 → sec1=5, dsec0=9.
- Priority and mid-run reset:
  - load during RUN is ignored.
  - stop and start_resume high together in RUN → PAUSED.
  - reset=0 mid-countdown → all outputs 0 next edge.
